// File: rtl/pkt_tx_50.sv
// pkt_tx_50: serial packet transmitter (50 MHz domain).
// Frames a header byte plus PAYLOAD_BYTES bytes popped from a FWFT FIFO,
// shifting each byte MSB first with data_ena high for its 8 bit-cycles.
module pkt_tx_50 #(
  parameter int unsigned PAYLOAD_BYTES = 4,
  parameter int unsigned GAP_CYCLES    = 2
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic       pkt_req,
  input  logic       pkt_sel,
  input  logic [7:0] fifo_data,
  input  logic       fifo_empty,
  output logic       fifo_rd,
  output logic       serial_data,
  output logic       data_ena,
  output logic       busy,
  output logic       pkt_done
);

  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [7:0]       HDR_TEMP  = 8'hA5;
  localparam logic [7:0]       HDR_CHECK = 8'hC3;
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [7:0]       LAST_BYTE = 8'(PAYLOAD_BYTES);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    GAP   = 3'd2,
    LOAD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state;
  logic [7:0]       shift_reg;
  logic [2:0]       bit_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [7:0]       byte_cnt;
  logic [7:0]       hdr;

  // Header byte selected by packet type
  assign hdr = pkt_sel ? HDR_CHECK : HDR_TEMP;

  // Pop strobe: the FIFO head is consumed on the same edge that loads it
  assign fifo_rd = (state == LOAD) && !fifo_empty;

  // Packet framing FSM with registered outputs
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      shift_reg   <= '0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      byte_cnt    <= '0;
      serial_data <= 1'b0;
      data_ena    <= 1'b0;
      busy        <= 1'b0;
      pkt_done    <= 1'b0;
    end else begin
      pkt_done <= 1'b0;
      case (state)
        IDLE: begin
          if (pkt_req) begin
            shift_reg   <= hdr;
            serial_data <= hdr[7];
            data_ena    <= 1'b1;
            busy        <= 1'b1;
            bit_cnt     <= '0;
            byte_cnt    <= '0;
            state       <= SHIFT;
          end
        end
        SHIFT: begin
          shift_reg <= {shift_reg[6:0], 1'b0};
          bit_cnt   <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            // Last bit of this byte is on the line; close the window
            serial_data <= 1'b0;
            data_ena    <= 1'b0;
            if (byte_cnt == LAST_BYTE) begin
              pkt_done <= 1'b1;
              state    <= DONE;
            end else begin
              gap_cnt <= '0;
              state   <= GAP;
            end
          end else begin
            serial_data <= shift_reg[6];
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= LOAD;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        LOAD: begin
          // Stall here while the FIFO is empty; no pop, line stays idle
          if (!fifo_empty) begin
            shift_reg   <= fifo_data;
            serial_data <= fifo_data[7];
            data_ena    <= 1'b1;
            bit_cnt     <= '0;
            byte_cnt    <= byte_cnt + 8'd1;
            state       <= SHIFT;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          serial_data <= 1'b0;
          data_ena    <= 1'b0;
          busy        <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_tx_50.sv
// tb_pkt_tx_50: scoreboard bench for pkt_tx_50 with a FWFT FIFO model
// and a serial deserializer comparing every byte against expectations.
module tb_pkt_tx_50;

  localparam int unsigned P = 4;
  localparam int unsigned G = 2;

  logic       clk_50 = 1'b0;
  logic       reset;
  logic       pkt_req;
  logic       pkt_sel;
  logic [7:0] fifo_data;
  logic       fifo_empty;
  logic       fifo_rd;
  logic       serial_data;
  logic       data_ena;
  logic       busy;
  logic       pkt_done;

  int tests = 0;
  int fails = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] hdr_q[$];
  logic [7:0] pay_q[$];
  int         low_q[$];

  int         pop_cnt = 0;
  int         bytes_seen = 0;
  logic       pop_pend = 1'b0;
  int         nbits = 0;
  int         idx = 0;
  int         hi_len = 0;
  int         lo_len = 0;
  logic       prev_ena = 1'b0;
  logic [7:0] sh = 8'h00;

  pkt_tx_50 #(
    .PAYLOAD_BYTES(P),
    .GAP_CYCLES   (G)
  ) dut (
    .clk_50     (clk_50),
    .reset      (reset),
    .pkt_req    (pkt_req),
    .pkt_sel    (pkt_sel),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .serial_data(serial_data),
    .data_ena   (data_ena),
    .busy       (busy),
    .pkt_done   (pkt_done)
  );

  always #5 clk_50 = ~clk_50;

  // Count one comparison and report a mismatch
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outs_zero(input string tag);
    check({tag, "_ser"},  32'(serial_data), 0);
    check({tag, "_ena"},  32'(data_ena),    0);
    check({tag, "_rd"},   32'(fifo_rd),     0);
    check({tag, "_busy"}, 32'(busy),        0);
    check({tag, "_done"}, 32'(pkt_done),    0);
  endtask

  task automatic refresh_fifo();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? 8'h00 : fifo_q[0];
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    pay_q.push_back(b);
    refresh_fifo();
  endtask

  // FIFO model: pop the head just after an edge on which fifo_rd was high
  always @(posedge clk_50) begin
    #1;
    if (pop_pend && fifo_q.size() != 0) void'(fifo_q.pop_front());
    refresh_fifo();
  end

  // Serial monitor: rebuild bytes, check windows, compare against scoreboard
  always @(negedge clk_50) begin
    logic [7:0] e;
    if (reset) begin
      nbits    = 0;
      idx      = 0;
      hi_len   = 0;
      lo_len   = 0;
      prev_ena = 1'b0;
      pop_pend = 1'b0;
      sh       = 8'h00;
    end else begin
      pop_pend = fifo_rd;
      if (fifo_rd) pop_cnt++;
      if (fifo_empty) check("rd_while_empty", 32'(fifo_rd), 0);
      if (pkt_done) begin
        check("done_busy", 32'(busy), 1);
        check("done_ena",  32'(data_ena), 0);
      end
      if (data_ena) begin
        if (!prev_ena) low_q.push_back(lo_len);
        hi_len++;
        lo_len = 0;
        sh = {sh[6:0], serial_data};
        nbits++;
        if (nbits == 8) begin
          if (idx == 0) begin
            if (hdr_q.size() == 0) check("hdr_unexpected", 32'(sh), 32'hFFFF_FFFF);
            else begin
              e = hdr_q.pop_front();
              check("hdr_byte", 32'(sh), 32'(e));
            end
          end else begin
            if (pay_q.size() == 0) check("pay_unexpected", 32'(sh), 32'hFFFF_FFFF);
            else begin
              e = pay_q.pop_front();
              check("pay_byte", 32'(sh), 32'(e));
            end
          end
          nbits = 0;
          bytes_seen++;
          idx = (idx == P) ? 0 : idx + 1;
        end
      end else begin
        if (prev_ena) check("ena_window", 32'(hi_len), 8);
        hi_len = 0;
        lo_len++;
      end
      prev_ena = data_ena;
    end
  end

  // Request one packet and follow it to pkt_done; optional stray request
  task automatic run_packet(input logic sel, input int exp_len, input string tag, input int pulse_at);
    int cyc      = 0;
    int busy_low = 0;
    int pops0    = pop_cnt;
    int bytes0   = bytes_seen;
    bit done     = 1'b0;
    low_q.delete();
    @(posedge clk_50); #1;
    pkt_req = 1'b1;
    pkt_sel = sel;
    hdr_q.push_back(sel ? 8'hC3 : 8'hA5);
    @(posedge clk_50); #1;
    pkt_req = 1'b0;
    while (!done && cyc < 500) begin
      @(negedge clk_50);
      cyc++;
      if (cyc == 1) begin
        check({tag, "_lat_ena"},  32'(data_ena), 1);
        check({tag, "_lat_busy"}, 32'(busy), 1);
      end
      if (pulse_at != 0 && cyc == pulse_at) begin
        pkt_req = 1'b1;
        pkt_sel = ~sel;
      end
      if (pulse_at != 0 && cyc == pulse_at + 1) begin
        pkt_req = 1'b0;
        pkt_sel = sel;
      end
      if (!busy) busy_low++;
      if (pkt_done) done = 1'b1;
    end
    check({tag, "_done_cyc"}, 32'(cyc), 32'(exp_len + 1));
    check({tag, "_busy_low"}, 32'(busy_low), 0);
    check({tag, "_pops"},     32'(pop_cnt - pops0), P);
    check({tag, "_bytes"},    32'(bytes_seen - bytes0), P + 1);
    @(negedge clk_50);
    check({tag, "_busy_clr"}, 32'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int   w;
    int   pops0;
    int   rises;
    int   busy_seen;
    logic prevd;

    reset   = 1'b1;
    pkt_req = 1'b1;
    pkt_sel = 1'b0;
    fifo_q.push_back(8'h99);
    fifo_q.push_back(8'h42);
    refresh_fifo();

    // Reset held with a request and a non-empty FIFO
    @(negedge clk_50);
    check_outs_zero("rst_a");
    repeat (3) @(negedge clk_50);
    check_outs_zero("rst_b");
    @(posedge clk_50); #1;
    pkt_req = 1'b0;
    fifo_q.delete();
    refresh_fifo();
    @(posedge clk_50); #1;
    reset = 1'b0;
    repeat (3) @(negedge clk_50);
    check("idle_busy", 32'(busy), 0);
    check("idle_ena",  32'(data_ena), 0);

    // Temperature packet
    push_byte(8'h12); push_byte(8'h34); push_byte(8'h56); push_byte(8'h78);
    run_packet(1'b0, 52, "temp", 0);
    check("temp_lows", 32'(low_q.size()), 5);
    for (int i = 1; i < 5 && i < low_q.size(); i++) check("temp_gap", 32'(low_q[i]), 3);

    // Check packet
    push_byte(8'hFF); push_byte(8'h00); push_byte(8'h81); push_byte(8'h7E);
    run_packet(1'b1, 52, "chk", 0);

    // Underrun: two bytes now, the rest pushed 10 cycles into the stall
    push_byte(8'hAA); push_byte(8'h55);
    fork
      run_packet(1'b0, 62, "udr", 0);
      begin
        pops0 = pop_cnt;
        w     = 0;
        while (pop_cnt < pops0 + 2 && w < 300) begin @(negedge clk_50); w++; end
        while (!data_ena && w < 300) begin @(negedge clk_50); w++; end
        while (data_ena && w < 300) begin @(negedge clk_50); w++; end
        if (w >= 300) check("udr_wait", 32'(w), 0);
        repeat (11) @(negedge clk_50);
        @(posedge clk_50); #1;
        push_byte(8'hC0);
        push_byte(8'h3F);
      end
    join
    check("udr_lows", 32'(low_q.size()), 5);
    if (low_q.size() == 5) begin
      check("udr_gap1", 32'(low_q[1]), 3);
      check("udr_gap2", 32'(low_q[2]), 3);
      check("udr_gap3", 32'(low_q[3]), 13);
      check("udr_gap4", 32'(low_q[4]), 3);
    end

    // Stray mid-packet request is ignored
    push_byte(8'h01); push_byte(8'h02); push_byte(8'h04); push_byte(8'h08);
    run_packet(1'b0, 52, "midreq", 20);
    busy_seen = 0;
    repeat (30) begin
      @(negedge clk_50);
      if (busy || data_ena) busy_seen++;
    end
    check("midreq_no_second", 32'(busy_seen), 0);

    // Back-to-back packets with pkt_req held high
    for (int i = 0; i < 8; i++) push_byte(8'(33 + i * 3));
    low_q.delete();
    pops0 = pop_cnt;
    @(posedge clk_50); #1;
    pkt_req = 1'b1;
    pkt_sel = 1'b0;
    hdr_q.push_back(8'hA5);
    hdr_q.push_back(8'hC3);
    @(posedge clk_50); #1;
    pkt_sel = 1'b1;
    w = 0;
    while (pkt_done !== 1'b1 && w < 200) begin @(negedge clk_50); w++; end
    check("b2b_first_done", 32'(w), 53);
    w = 0;
    while (data_ena !== 1'b1 && w < 20) begin @(negedge clk_50); w++; end
    check("b2b_gap", 32'(w), 2);
    @(posedge clk_50); #1;
    pkt_req = 1'b0;
    pkt_sel = 1'b0;
    w = 0;
    while (pkt_done !== 1'b1 && w < 200) begin @(negedge clk_50); w++; end
    check("b2b_second_done", 32'(w), 52);
    check("b2b_pops", 32'(pop_cnt - pops0), 8);
    check("b2b_lows", 32'(low_q.size()), 10);
    if (low_q.size() == 10) check("b2b_low_between", 32'(low_q[5]), 2);
    @(negedge clk_50);
    check("b2b_busy_clr", 32'(busy), 0);

    // Reset during bit 4 of payload byte 2
    for (int i = 0; i < 4; i++) push_byte(8'(224 + i));
    hdr_q.push_back(8'hA5);
    @(posedge clk_50); #1;
    pkt_req = 1'b1;
    pkt_sel = 1'b0;
    @(posedge clk_50); #1;
    pkt_req = 1'b0;
    rises = 0;
    w     = 0;
    prevd = 1'b0;
    while (rises < 3 && w < 200) begin
      @(negedge clk_50);
      w++;
      if (data_ena && !prevd) rises++;
      prevd = data_ena;
    end
    check("rstmid_reach", 32'(rises), 3);
    repeat (3) @(posedge clk_50);
    #1;
    reset = 1'b1;
    #1;
    check_outs_zero("rstmid_now");
    check("rstmid_fifo_left", 32'(fifo_q.size()), 2);
    hdr_q.delete();
    pay_q = fifo_q;
    repeat (2) @(negedge clk_50);
    check_outs_zero("rstmid_hold");
    @(posedge clk_50); #1;
    reset = 1'b0;
    pops0 = pop_cnt;
    repeat (5) @(negedge clk_50);
    check("rstmid_idle_busy", 32'(busy), 0);
    check("rstmid_idle_rd",   32'(fifo_rd), 0);
    check("rstmid_no_pop",    32'(pop_cnt - pops0), 0);
    push_byte(8'h5A);
    push_byte(8'hA5);
    run_packet(1'b0, 52, "fresh", 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
